// File: rtl/sniffer_mem_pkg.sv
// Shared definitions for the sniffer memory path.
// Contents:
//   RAM_ADDR_WIDTH / RAM_DATA_WIDTH : default write-port widths
//   wr_arb_state_e                  : write arbiter FSM states
//   grant_onehot()                  : maps an arbiter state to its one-hot grant code
package sniffer_mem_pkg;

  localparam int RAM_ADDR_WIDTH = 29;
  localparam int RAM_DATA_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } wr_arb_state_e;

  function automatic logic [1:0] grant_onehot(input wr_arb_state_e st);
    case (st)
      ST_GRANT0: return 2'b01;
      ST_GRANT1: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ram_write_arbiter.sv
// Two-client write arbiter in front of a single RAM write port.
// A client owns the port for a burst; beats pass through combinationally
// (zero latency) while it is granted. Bursts are capped at MAX_BURST beats,
// ties in IDLE are broken round-robin, and ownership hands straight over to
// a waiting client with no idle cycle.
// Ports:
//   clk_ram, rst_n              : clock, asynchronous active-low reset
//   laN_wr_en                   : client N wants the port (N = 0, 1)
//   laN_wr_valid/addr/data      : client N beat, held stable until acked
//   laN_wr_ack                  : one-cycle pulse per accepted beat
//   mem_wr_valid/addr/data      : beat offered to the memory port
//   mem_wr_ready                : memory port acceptance
//   grant                       : one-hot current owner, 00 = idle
module ram_write_arbiter
  import sniffer_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int MAX_BURST  = 64
) (
  input  logic                  clk_ram,
  input  logic                  rst_n,
  input  logic                  la0_wr_en,
  input  logic                  la0_wr_valid,
  input  logic [ADDR_WIDTH-1:0] la0_wr_addr,
  input  logic [DATA_WIDTH-1:0] la0_wr_data,
  output logic                  la0_wr_ack,
  input  logic                  la1_wr_en,
  input  logic                  la1_wr_valid,
  input  logic [ADDR_WIDTH-1:0] la1_wr_addr,
  input  logic [DATA_WIDTH-1:0] la1_wr_data,
  output logic                  la1_wr_ack,
  output logic                  mem_wr_valid,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_ready,
  output logic [1:0]            grant
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  wr_arb_state_e    state_reg, state_next;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic             last_grant_reg;   // 1: client 1 was granted most recently
  logic [1:0]       grant_reg;
  logic             beat_done;
  logic             burst_end;
  logic             enter_grant;

  // Data path: the owner's beat passes straight through; idle drives zeros.
  always_comb begin
    mem_wr_valid = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    case (state_reg)
      ST_GRANT0: begin
        mem_wr_valid = la0_wr_valid;
        mem_wr_addr  = la0_wr_addr;
        mem_wr_data  = la0_wr_data;
      end
      ST_GRANT1: begin
        mem_wr_valid = la1_wr_valid;
        mem_wr_addr  = la1_wr_addr;
        mem_wr_data  = la1_wr_data;
      end
      default: ;
    endcase
  end

  assign la0_wr_ack = (state_reg == ST_GRANT0) & la0_wr_valid & mem_wr_ready;
  assign la1_wr_ack = (state_reg == ST_GRANT1) & la1_wr_valid & mem_wr_ready;

  assign beat_done = la0_wr_ack | la1_wr_ack;
  assign burst_end = beat_done & (beat_cnt_reg == LAST_BEAT);

  always_comb begin
    state_next  = state_reg;
    enter_grant = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (la0_wr_en && la1_wr_en)
          state_next = last_grant_reg ? ST_GRANT0 : ST_GRANT1;
        else if (la0_wr_en)
          state_next = ST_GRANT0;
        else if (la1_wr_en)
          state_next = ST_GRANT1;
      end
      ST_GRANT0: begin
        // A pending (valid, not yet accepted) beat keeps the grant alive.
        if (burst_end || (!la0_wr_en && (!la0_wr_valid || la0_wr_ack))) begin
          if (la1_wr_en)
            state_next = ST_GRANT1;
          else if (burst_end && la0_wr_en)
            state_next = ST_GRANT0;
          else
            state_next = ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (burst_end || (!la1_wr_en && (!la1_wr_valid || la1_wr_ack))) begin
          if (la0_wr_en)
            state_next = ST_GRANT0;
          else if (burst_end && la1_wr_en)
            state_next = ST_GRANT1;
          else
            state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Staying in the same grant state only happens as a burst-limit re-entry.
    enter_grant = (state_next != ST_IDLE) && ((state_next != state_reg) || burst_end);
  end

  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      beat_cnt_reg   <= '0;
      last_grant_reg <= 1'b1;
      grant_reg      <= 2'b00;
    end else begin
      state_reg <= state_next;
      // Encoded from the next state so grant lines up with state_reg.
      grant_reg <= grant_onehot(state_next);
      if (enter_grant) begin
        beat_cnt_reg   <= '0;
        last_grant_reg <= (state_next == ST_GRANT1);
      end else if (beat_done) begin
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign grant = grant_reg;

  a_single_ack: assert property (@(posedge clk_ram) disable iff (!rst_n)
    !(la0_wr_ack && la1_wr_ack));

  a_idle_quiet: assert property (@(posedge clk_ram) disable iff (!rst_n)
    !((state_reg == ST_IDLE) && mem_wr_valid));

  a_hold_stable: assert property (@(posedge clk_ram) disable iff (!rst_n)
    (mem_wr_valid && !mem_wr_ready) |=>
      (mem_wr_valid && $stable(mem_wr_addr) && $stable(mem_wr_data)));

endmodule
